// File: rtl/canvas_downsampler_pkg.sv
// Shared FSM state, output-pixel record and address/index widths for the canvas downsampler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package digit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } ds_state_t;

    localparam int OUT_PIXELS = 784;
    localparam int IDX_W      = $clog2(OUT_PIXELS);
    localparam int FB_ADDR_W  = 17;
    localparam int BLOCK_DEF  = 8;
    localparam int BLK_SHIFT  = $clog2(BLOCK_DEF);

    typedef struct packed {
        logic [7:0]       data;
        logic [IDX_W-1:0] index;
        logic             last;
    } pix_t;

    // Mean of BLOCK x BLOCK 8-bit samples needs 2*log2(BLOCK) extra bits.
    function automatic int acc_width(input int block);
        return 8 + 2 * $clog2(block);
    endfunction

endpackage

// File: rtl/canvas_downsampler_if.sv
// Downsampled pixel stream: valid/ready handshake carrying block mean, index and last flag.
// Latency: none (wires only).
// Backpressure: source holds all fields while pix_valid && !pix_ready.
interface canvas_downsampler_if;
    import digit_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    logic [7:0]       pix_data;
    logic [IDX_W-1:0] pix_index;
    logic             pix_last;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_index,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_index,
        input  pix_last,
        output pix_ready
    );

endinterface

// File: rtl/canvas_downsampler_addr_gen.sv
// Walks block (ox,oy) and sub-pixel (sx,sy) counters, producing framebuffer addresses incrementally.
// Latency: addr is combinational from the counter registers; counters step on the same edge as issue.
// Backpressure: none; block counters only advance when the caller pulses advance.
module ds_addr_gen
    import digit_pkg::*;
#(
    parameter int FB_WIDTH = 320,
    parameter int CANVAS_X = 48,
    parameter int CANVAS_Y = 8,
    parameter int BLOCK    = BLOCK_DEF,
    parameter int OUT_DIM  = 28
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 init,
    input  logic                 issue,
    input  logic                 advance,
    output logic [FB_ADDR_W-1:0] addr,
    output logic                 last_issue,
    output logic                 last_block
);

    localparam int SW = (BLOCK > 1) ? $clog2(BLOCK) : 1;
    localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [SW-1:0]        SUB_MAX   = SW'(BLOCK - 1);
    localparam logic [OW-1:0]        OUT_MAX   = OW'(OUT_DIM - 1);
    localparam logic [FB_ADDR_W-1:0] TOP_ROW   = FB_ADDR_W'(CANVAS_Y * FB_WIDTH);
    localparam logic [FB_ADDR_W-1:0] ROW_STEP  = FB_ADDR_W'(FB_WIDTH);
    localparam logic [FB_ADDR_W-1:0] BAND_STEP = FB_ADDR_W'(BLOCK * FB_WIDTH);
    localparam logic [FB_ADDR_W-1:0] LEFT_COL  = FB_ADDR_W'(CANVAS_X);
    localparam logic [FB_ADDR_W-1:0] COL_STEP  = FB_ADDR_W'(BLOCK);

    logic [SW-1:0]        sx;
    logic [SW-1:0]        sy;
    logic [OW-1:0]        ox;
    logic [OW-1:0]        oy;
    logic [FB_ADDR_W-1:0] band_base;
    logic [FB_ADDR_W-1:0] row_base;
    logic [FB_ADDR_W-1:0] col_base;

    // band_base is the first row of the current block band; row_base tracks sy within it.
    assign addr       = row_base + col_base + FB_ADDR_W'(sx);
    assign last_issue = issue && (sx == SUB_MAX) && (sy == SUB_MAX);
    assign last_block = (ox == OUT_MAX) && (oy == OUT_MAX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx        <= '0;
            sy        <= '0;
            ox        <= '0;
            oy        <= '0;
            band_base <= '0;
            row_base  <= '0;
            col_base  <= '0;
        end else if (init) begin
            sx        <= '0;
            sy        <= '0;
            ox        <= '0;
            oy        <= '0;
            band_base <= TOP_ROW;
            row_base  <= TOP_ROW;
            col_base  <= LEFT_COL;
        end else if (issue) begin
            if (sx == SUB_MAX) begin
                sx <= '0;
                if (sy == SUB_MAX) begin
                    sy       <= '0;
                    row_base <= band_base;
                end else begin
                    sy       <= sy + 1'b1;
                    row_base <= row_base + ROW_STEP;
                end
            end else begin
                sx <= sx + 1'b1;
            end
        end else if (advance) begin
            if (ox == OUT_MAX) begin
                ox        <= '0;
                oy        <= oy + 1'b1;
                col_base  <= LEFT_COL;
                band_base <= band_base + BAND_STEP;
                row_base  <= band_base + BAND_STEP;
            end else begin
                ox       <= ox + 1'b1;
                col_base <= col_base + COL_STEP;
            end
        end
    end

endmodule

// File: rtl/canvas_downsampler.sv
// Reduces the framebuffer canvas to OUT_DIM x OUT_DIM block means, streamed in row-major order.
// Latency: first pixel BLOCK^2+RD_LATENCY cycles after READ entry; one EMIT cycle per transfer.
// Backpressure: EMIT holds pix_* stable until pix_ready; no reads are issued while stalled.
module canvas_downsampler
    import digit_pkg::*;
#(
    parameter int FB_WIDTH   = 320,
    parameter int CANVAS_X   = 48,
    parameter int CANVAS_Y   = 8,
    parameter int BLOCK      = BLOCK_DEF,
    parameter int OUT_DIM    = 28,
    parameter int RD_LATENCY = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [FB_ADDR_W-1:0] fb_rdaddress,
    input  logic [7:0]           fb_q,
    canvas_downsampler_if.master pix
);

    localparam int BS    = $clog2(BLOCK);
    localparam int ACC_W = acc_width(BLOCK);
    localparam int DW    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [DW-1:0] DRAIN_MAX = DW'(RD_LATENCY - 1);

    ds_state_t              state;
    ds_state_t              state_nxt;
    logic                   init;
    logic                   issue;
    logic                   xfer;
    logic                   drain_end;
    logic                   emit_vld;
    logic [FB_ADDR_W-1:0]   addr;
    logic                   last_issue;
    logic                   last_block;
    logic [RD_LATENCY-1:0]  rd_pipe;
    logic                   tap;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_nxt;
    logic [DW-1:0]          drain_cnt;
    pix_t                   pix_q;

    ds_addr_gen #(
        .FB_WIDTH (FB_WIDTH),
        .CANVAS_X (CANVAS_X),
        .CANVAS_Y (CANVAS_Y),
        .BLOCK    (BLOCK),
        .OUT_DIM  (OUT_DIM)
    ) u_addr_gen (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .init       (init),
        .issue      (issue),
        .advance    (xfer),
        .addr       (addr),
        .last_issue (last_issue),
        .last_block (last_block)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        init      = 1'b0;
        issue     = 1'b0;
        xfer      = 1'b0;
        drain_end = 1'b0;
        emit_vld  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    init      = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                busy  = 1'b1;
                issue = 1'b1;
                if (last_issue) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_MAX) begin
                    drain_end = 1'b1;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                busy     = 1'b1;
                emit_vld = 1'b1;
                if (pix.pix_ready) begin
                    xfer      = 1'b1;
                    state_nxt = last_block ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The tap marks the cycle in which fb_q carries the sample for a read issued RD_LATENCY ago.
    assign tap     = rd_pipe[RD_LATENCY-1];
    assign acc_nxt = acc + (tap ? ACC_W'(fb_q) : '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_pipe   <= '0;
            drain_cnt <= '0;
            acc       <= '0;
            pix_q     <= '0;
        end else begin
            rd_pipe[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;

            if (init || xfer) begin
                acc <= '0;
            end else if (tap) begin
                acc <= acc_nxt;
            end

            // The final sample lands in the same cycle DRAIN ends, so capture from acc_nxt.
            if (init) begin
                pix_q <= '0;
            end else if (drain_end) begin
                pix_q.data <= acc_nxt[2*BS +: 8];
                pix_q.last <= last_block;
            end else if (xfer) begin
                pix_q.index <= pix_q.index + 1'b1;
            end
        end
    end

    assign fb_rdaddress  = issue ? addr : '0;
    assign pix.pix_valid = emit_vld;
    assign pix.pix_data  = pix_q.data;
    assign pix.pix_index = pix_q.index;
    assign pix.pix_last  = pix_q.last;

endmodule

// File: tb/tb_canvas_downsampler.sv
// Bench for canvas_downsampler: framebuffer model with read latency, block-mean reference and stream monitor.
module tb_canvas_downsampler;
    import digit_pkg::*;

    localparam int FB_WIDTH   = 320;
    localparam int CANVAS_X   = 48;
    localparam int CANVAS_Y   = 8;
    localparam int BLOCK      = 8;
    localparam int OUT_DIM    = 28;
    localparam int RD_LATENCY = 2;
    localparam int NPIX       = OUT_DIM * OUT_DIM;
    localparam int FB_SIZE    = 131072;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [16:0] fb_rdaddress;
    logic [7:0]  fb_q;

    canvas_downsampler_if pix();

    canvas_downsampler #(
        .FB_WIDTH   (FB_WIDTH),
        .CANVAS_X   (CANVAS_X),
        .CANVAS_Y   (CANVAS_Y),
        .BLOCK      (BLOCK),
        .OUT_DIM    (OUT_DIM),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .fb_rdaddress (fb_rdaddress),
        .fb_q         (fb_q),
        .pix          (pix)
    );

    always #5 Clk = ~Clk;

    logic [7:0] fb_mem [FB_SIZE];
    logic [7:0] q_pipe [RD_LATENCY];

    always @(posedge Clk) begin
        q_pipe[0] <= fb_mem[fb_rdaddress];
        for (int i = 1; i < RD_LATENCY; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign fb_q = q_pipe[RD_LATENCY-1];

    int n_vec = 0;
    int n_err = 0;
    int exp_pix [NPIX];
    int cap_data [NPIX];
    int frame_id = 0;
    int frame_seen = 0;
    int exp_idx = 0;
    int n_xfer = 0;
    int addr_k = 0;
    int last_addr = 0;
    int ready_mode = 0;
    bit expect_done = 0;
    bit stalled = 0;
    int h_data, h_idx, h_last;

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic int canvas_addr(input int cx, input int cy);
        return (CANVAS_Y + cy) * FB_WIDTH + CANVAS_X + cx;
    endfunction

    // k-th read of a frame: blocks in row-major order, sub-pixels row-major inside each block.
    function automatic int addr_of(input int k);
        int p, s;
        p = k / (BLOCK * BLOCK);
        s = k % (BLOCK * BLOCK);
        return canvas_addr((p % OUT_DIM) * BLOCK + s % BLOCK, (p / OUT_DIM) * BLOCK + s / BLOCK);
    endfunction

    task automatic compute_model();
        for (int p = 0; p < NPIX; p++) begin
            int sum;
            sum = 0;
            for (int y = 0; y < BLOCK; y++)
                for (int x = 0; x < BLOCK; x++)
                    sum += int'(fb_mem[canvas_addr((p % OUT_DIM) * BLOCK + x, (p / OUT_DIM) * BLOCK + y)]);
            exp_pix[p] = sum / (BLOCK * BLOCK);
        end
    endtask

    task automatic fill_all(input logic [7:0] v);
        for (int i = 0; i < FB_SIZE; i++) fb_mem[i] = v;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(pix.pix_valid), 0);
        chk({tag, "_data"}, int'(pix.pix_data), 0);
        chk({tag, "_index"}, int'(pix.pix_index), 0);
        chk({tag, "_last"}, int'(pix.pix_last), 0);
        chk({tag, "_rdaddress"}, int'(fb_rdaddress), 0);
    endtask

    task automatic start_frame();
        frame_id++;
        @(negedge Clk);
        chk("idle_busy", int'(busy), 0);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("first_addr", int'(fb_rdaddress), 2608);
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int c;
        c = 0;
        while (n_xfer < n && c < budget) begin
            @(negedge Clk);
            c++;
        end
        chk("xfer_budget", (n_xfer >= n) ? 1 : 0, 1);
    endtask

    // Monitor: drives pix_ready for the coming edge, then scores what that edge will transfer.
    always @(negedge Clk) begin
        case (ready_mode)
            0:       pix.pix_ready = 1'b1;
            1:       pix.pix_ready = 1'($urandom_range(0, 1));
            default: pix.pix_ready = 1'b0;
        endcase
        if (!Reset_n) begin
            stalled     = 0;
            expect_done = 0;
        end else begin
            if (frame_seen != frame_id) begin
                frame_seen = frame_id;
                exp_idx = 0;
                n_xfer  = 0;
                addr_k  = 0;
                for (int i = 0; i < NPIX; i++) cap_data[i] = -1;
            end
            if (expect_done) begin
                chk("done_pulse", int'(done), 1);
                chk("busy_in_done", int'(busy), 0);
                expect_done = 0;
            end else if (done) begin
                chk("done_spurious", int'(done), 0);
            end
            if (fb_rdaddress != 0) begin
                chk("rdaddress", int'(fb_rdaddress), addr_of(addr_k));
                last_addr = int'(fb_rdaddress);
                addr_k++;
            end
            if (stalled) begin
                chk("stall_valid", int'(pix.pix_valid), 1);
                chk("stall_data", int'(pix.pix_data), h_data);
                chk("stall_index", int'(pix.pix_index), h_idx);
                chk("stall_last", int'(pix.pix_last), h_last);
            end
            stalled = 0;
            if (pix.pix_valid && pix.pix_ready) begin
                chk("index", int'(pix.pix_index), exp_idx);
                chk("data", int'(pix.pix_data), (exp_idx < NPIX) ? exp_pix[exp_idx] : -1);
                chk("last", int'(pix.pix_last), (exp_idx == NPIX - 1) ? 1 : 0);
                if (int'(pix.pix_index) < NPIX) cap_data[pix.pix_index] = int'(pix.pix_data);
                if (pix.pix_last) expect_done = 1;
                exp_idx++;
                n_xfer++;
            end else if (pix.pix_valid) begin
                stalled = 1;
                h_data  = int'(pix.pix_data);
                h_idx   = int'(pix.pix_index);
                h_last  = int'(pix.pix_last);
            end
        end
    end

    typedef struct packed {
        logic [9:0] idx;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int cnt;
        bit seen;

        tbl[0] = {10'd0,   8'd3};
        tbl[1] = {10'd1,   8'd0};
        tbl[2] = {10'd27,  8'd0};
        tbl[3] = {10'd28,  8'd0};
        tbl[4] = {10'd115, 8'd0};
        tbl[5] = {10'd142, 8'd0};
        tbl[6] = {10'd143, 8'd128};
        tbl[7] = {10'd144, 8'd0};

        repeat (3) @(negedge Clk);
        check_zero("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        // All-0xFF frame, aborted by reset after 100 transfers.
        fill_all(8'hFF);
        compute_model();
        ready_mode = 0;
        start_frame();
        wait_xfers(100, 8000);
        chk("ff_pix5", cap_data[5], 255);
        #2 Reset_n = 1'b0;
        #1 check_zero("midreset");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Sparse canvas: one bright pixel at (0,0), block (3,5) filled with 0x80.
        fill_all(8'h00);
        fb_mem[canvas_addr(0, 0)] = 8'hFF;
        for (int y = 0; y < BLOCK; y++)
            for (int x = 0; x < BLOCK; x++)
                fb_mem[canvas_addr(3 * BLOCK + x, 5 * BLOCK + y)] = 8'h80;
        compute_model();
        start_frame();
        wait_xfers(145, 12000);
        for (int i = 0; i < 8; i++)
            chk($sformatf("tbl_idx%0d", int'(tbl[i].idx)), cap_data[tbl[i].idx], int'(tbl[i].data));
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;

        // Full random frame with an initial stall, random ready, and ignored start pulses.
        for (int i = 0; i < FB_SIZE; i++) fb_mem[i] = 8'($urandom);
        compute_model();
        ready_mode = 2;
        start_frame();
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 200) begin
            @(negedge Clk);
            cnt++;
            seen = pix.pix_valid;
        end
        chk("first_valid_latency", cnt, BLOCK * BLOCK + RD_LATENCY);
        repeat (10) @(negedge Clk);
        ready_mode = 1;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("busy_mid_start", int'(busy), 1);
        wait_xfers(40, 8000);
        ready_mode = 0;
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 60000) begin
            @(negedge Clk);
            cnt++;
            seen = pix.pix_valid && pix.pix_last;
        end
        chk("frame_end_seen", seen ? 1 : 0, 1);
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("done_start_busy", int'(busy), 0);
        chk("done_start_rdaddress", int'(fb_rdaddress), 0);
        chk("done_start_valid", int'(pix.pix_valid), 0);
        repeat (3) @(negedge Clk);
        chk("frame_xfers", n_xfer, NPIX);
        chk("last_addr", last_addr, 74191);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
